mem_access_arbiter: RTL

Sequences all accesses to the single-ported main memory in the 32-bit multicycle CPU. It shares the memory between the instruction-fetch requester and the data (load/store) requester. Arbitration between them is round-robin. On read completion it pulses `mdr_write`, so the Memory Data Register captures the memory read data in the cycle that data is valid.

---
 rtl/mem_access_arbiter.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/mem_access_arbiter.sv
// mem_access_arbiter
// Shares the single-ported main memory between the instruction-fetch
// requester and the data (load/store) requester with round-robin
// arbitration. Each access runs IDLE -> ACCESS -> DONE; a completed read
// pulses mdr_write so the MDR captures memory read data in the DONE cycle.
// Optional feature: define MEM_ARB_TIMEOUT_EN to abort an access that has
// waited TIMEOUT cycles without mem_ready (reported with an err pulse).
module mem_access_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_done,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_done,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  output logic              mdr_write,
  output logic              err
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } state_e;

  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_D  = 1'b1;

  state_e            state_q;
  logic              last_owner_q;
  logic              owner_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              if_gnt_q;
  logic              d_gnt_q;
  logic              if_done_q;
  logic              d_done_q;
  logic              mem_en_q;
  logic              mem_we_q;
  logic              mdr_write_q;

  logic              grant_if;
  logic              grant_d;

`ifdef MEM_ARB_TIMEOUT_EN
  // Count value at which the next wait cycle would reach TIMEOUT.
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);
  logic [7:0] cnt_q;
  logic       err_q;
`else
  // TIMEOUT only matters when the abort feature is built in.
  logic [7:0] timeout_unused;
  assign timeout_unused = 8'(TIMEOUT);
`endif

  // Round-robin pick: a lone request wins; on contention the requester
  // that did not own the previous access wins.
  always_comb begin
    grant_if = 1'b0;
    grant_d  = 1'b0;
    if (if_req && d_req) begin
      if (last_owner_q == OWN_D) begin
        grant_if = 1'b1;
      end else begin
        grant_d = 1'b1;
      end
    end else if (if_req) begin
      grant_if = 1'b1;
    end else if (d_req) begin
      grant_d = 1'b1;
    end else begin
      grant_if = 1'b0;
      grant_d  = 1'b0;
    end
  end

  // Access sequencer: state, captured access and all registered strobes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      last_owner_q <= OWN_D;
      owner_q      <= OWN_IF;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      if_gnt_q     <= 1'b0;
      d_gnt_q      <= 1'b0;
      if_done_q    <= 1'b0;
      d_done_q     <= 1'b0;
      mem_en_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mdr_write_q  <= 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
      cnt_q        <= 8'd0;
      err_q        <= 1'b0;
`endif
    end else begin
      // Pulses default low; they are raised for exactly one cycle below.
      if_gnt_q    <= 1'b0;
      d_gnt_q     <= 1'b0;
      if_done_q   <= 1'b0;
      d_done_q    <= 1'b0;
      mdr_write_q <= 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
      err_q       <= 1'b0;
`endif
      case (state_q)
        S_IDLE: begin
          if (grant_if) begin
            addr_q       <= if_addr;
            we_q         <= 1'b0;
            wdata_q      <= '0;
            owner_q      <= OWN_IF;
            last_owner_q <= OWN_IF;
            if_gnt_q     <= 1'b1;
            mem_en_q     <= 1'b1;
            mem_we_q     <= 1'b0;
            state_q      <= S_ACCESS;
`ifdef MEM_ARB_TIMEOUT_EN
            cnt_q        <= 8'd0;
`endif
          end else if (grant_d) begin
            addr_q       <= d_addr;
            we_q         <= d_we;
            wdata_q      <= d_wdata;
            owner_q      <= OWN_D;
            last_owner_q <= OWN_D;
            d_gnt_q      <= 1'b1;
            mem_en_q     <= 1'b1;
            mem_we_q     <= d_we;
            state_q      <= S_ACCESS;
`ifdef MEM_ARB_TIMEOUT_EN
            cnt_q        <= 8'd0;
`endif
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_ACCESS: begin
          if (mem_ready) begin
            state_q     <= S_DONE;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            if_done_q   <= (owner_q == OWN_IF);
            d_done_q    <= (owner_q == OWN_D);
            mdr_write_q <= ~we_q;
          end
`ifdef MEM_ARB_TIMEOUT_EN
          else if (cnt_q == TIMEOUT_LAST) begin
            // Abort: the requester still sees done, but no read data is taken.
            state_q     <= S_DONE;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            if_done_q   <= (owner_q == OWN_IF);
            d_done_q    <= (owner_q == OWN_D);
            mdr_write_q <= 1'b0;
            err_q       <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
`else
          else begin
            state_q <= S_ACCESS;
          end
`endif
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q  <= S_IDLE;
          mem_en_q <= 1'b0;
          mem_we_q <= 1'b0;
        end
      endcase
    end
  end

  assign if_gnt    = if_gnt_q;
  assign d_gnt     = d_gnt_q;
  assign if_done   = if_done_q;
  assign d_done    = d_done_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mdr_write = mdr_write_q;
`ifdef MEM_ARB_TIMEOUT_EN
  assign err       = err_q;
`else
  assign err       = 1'b0;
`endif

endmodule
